cache_mem_responder: RTL and testbench

- Responder end of the cache's refill/write-back request interface (rd_req/rd_rdy/ret_*, wr_req/wr_rdy).
- Serves line (4-word) and single-word reads and writes from an internal word-addressed memory, with programmable latency.
- Used as the memory side under the I/D caches in simulation and in SoC-lite builds where there is no AXI bridge.

---
 rtl/cache_mem_responder.sv | 188 ++++++++++++++++++
 tb/tb_cache_mem_responder.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_responder.sv
// Memory-side responder for the cache refill/write-back interface: serves line and
// word reads/writes from an internal word array. Macro RESP_BEAT_GAP_EN adds read-beat bubbles.
module cache_mem_responder #(
  parameter int ADDR_W = 14,
  parameter int RD_LAT = 2,
  parameter int WR_LAT = 1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [2:0]   rd_type,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic         ret_last,
  output logic [31:0]  ret_data,
  input  logic         wr_req,
  input  logic [2:0]   wr_type,
  input  logic [31:0]  wr_addr,
  input  logic [3:0]   wr_wstrb,
  input  logic [127:0] wr_data,
  output logic         wr_rdy
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RD_BURST, WR_BUSY} state_t;

`ifdef RESP_BEAT_GAP_EN
  localparam bit GAP_EN = 1'b1;
`else
  localparam bit GAP_EN = 1'b0;
`endif

  localparam logic [7:0] RD_WAIT_INIT = (RD_LAT > 1) ? 8'(RD_LAT - 2) : 8'd0;
  localparam logic [7:0] WR_INIT      = (WR_LAT > 1) ? 8'(WR_LAT - 1) : 8'd0;

  logic [31:0]       r_mem [0:(1 << ADDR_W) - 1];
  state_t            r_state;
  state_t            w_next;
  logic [7:0]        r_cnt;
  logic [1:0]        r_beat;
  logic              r_line;
  logic [ADDR_W-1:0] r_idx;
  logic              r_wr_line;
  logic [3:0]        r_wr_wstrb;
  logic [127:0]      r_wr_data;
  logic              r_ready;
  logic              r_ret_valid;
  logic              r_ret_last;
  logic [31:0]       r_ret_data;

  logic              w_emit;
  logic [1:0]        w_emit_beat;
  logic              w_emit_line;
  logic [ADDR_W-1:0] w_emit_base;
  logic [ADDR_W-1:0] w_emit_idx;
  logic              w_emit_last;
  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_mem_we;
  logic              w_unused;

  assign w_unused = ^{rd_addr[31:ADDR_W+2], rd_addr[1:0], wr_addr[31:ADDR_W+2], wr_addr[1:0]};

  // w_emit marks an edge that loads a beat into the registered return outputs,
  // so r_state tracks what the outputs are showing during the current cycle.
  always_comb begin
    w_next      = r_state;
    w_emit      = 1'b0;
    w_emit_beat = r_beat;
    w_emit_line = r_line;
    w_emit_base = r_idx;
    w_rd_acc    = 1'b0;
    w_wr_acc    = 1'b0;
    w_mem_we    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_ready && wr_req) begin
          w_wr_acc = 1'b1;
          w_next   = WR_BUSY;
        end else if (r_ready && rd_req) begin
          w_rd_acc    = 1'b1;
          w_emit_line = (rd_type == 3'b100);
          w_emit_base = rd_addr[ADDR_W+1:2];
          w_emit_beat = 2'd0;
          if (RD_LAT <= 1) begin
            w_next = RD_BURST;
            w_emit = 1'b1;
          end else begin
            w_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        if (r_cnt == 8'd0) begin
          w_next      = RD_BURST;
          w_emit      = 1'b1;
          w_emit_beat = 2'd0;
        end
      end
      RD_BURST: begin
        if (r_ret_last) begin
          w_next = IDLE;
        end else if (!(GAP_EN && r_ret_valid)) begin
          w_emit      = 1'b1;
          w_emit_beat = r_beat + 2'd1;
        end
      end
      WR_BUSY: begin
        if (r_cnt == 8'd0) begin
          w_mem_we = 1'b1;
          w_next   = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_emit_idx  = w_emit_line ? {w_emit_base[ADDR_W-1:2], w_emit_beat} : w_emit_base;
  assign w_emit_last = !w_emit_line || (w_emit_beat == 2'd3);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_cnt       <= 8'd0;
      r_beat      <= 2'd0;
      r_line      <= 1'b0;
      r_idx       <= '0;
      r_wr_line   <= 1'b0;
      r_wr_wstrb  <= 4'd0;
      r_wr_data   <= 128'd0;
      r_ready     <= 1'b0;
      r_ret_valid <= 1'b0;
      r_ret_last  <= 1'b0;
      r_ret_data  <= 32'd0;
    end else begin
      r_state     <= w_next;
      r_ready     <= (w_next == IDLE);
      r_ret_valid <= w_emit;
      r_ret_last  <= w_emit && w_emit_last;
      if (w_emit) begin
        r_ret_data <= r_mem[w_emit_idx];
        r_beat     <= w_emit_beat;
      end
      if (w_rd_acc) begin
        r_idx  <= rd_addr[ADDR_W+1:2];
        r_line <= (rd_type == 3'b100);
        r_beat <= 2'd0;
        r_cnt  <= RD_WAIT_INIT;
      end else if (w_wr_acc) begin
        r_idx      <= wr_addr[ADDR_W+1:2];
        r_wr_line  <= (wr_type == 3'b100);
        r_wr_wstrb <= wr_wstrb;
        r_wr_data  <= wr_data;
        r_cnt      <= WR_INIT;
      end else if ((r_state == RD_WAIT || r_state == WR_BUSY) && r_cnt != 8'd0) begin
        r_cnt <= r_cnt - 8'd1;
      end
    end
  end

  // Commit happens on the edge leaving WR_BUSY, so the next IDLE read sees it.
  always_ff @(posedge clk) begin
    if (resetn && w_mem_we) begin
      if (r_wr_line) begin
        for (int i = 0; i < 4; i++)
          r_mem[{r_idx[ADDR_W-1:2], 2'(i)}] <= r_wr_data[32*i +: 32];
      end else begin
        for (int b = 0; b < 4; b++)
          if (r_wr_wstrb[b]) r_mem[r_idx][8*b +: 8] <= r_wr_data[8*b +: 8];
      end
    end
  end

`ifdef RESP_BEAT_GAP_EN
  logic r_proto_err;
  always_ff @(posedge clk) begin
    if (!resetn) r_proto_err <= 1'b0;
    else if (wr_req && r_state != IDLE) r_proto_err <= 1'b1;
  end
`endif

  assign rd_rdy    = r_ready;
  assign wr_rdy    = r_ready;
  assign ret_valid = r_ret_valid;
  assign ret_last  = r_ret_last;
  assign ret_data  = r_ret_data;

endmodule

// File: tb/tb_cache_mem_responder.sv
// Bench for cache_mem_responder: directed cases plus random traffic against a word-array model.
module tb_cache_mem_responder;

  localparam int ADDR_W = 14;
  localparam int RD_LAT = 2;
  localparam int WR_LAT = 1;
`ifdef RESP_BEAT_GAP_EN
  localparam int STEP = 2;
`else
  localparam int STEP = 1;
`endif
  localparam int EW = 49;  // {expected cycle[15:0], last, data[31:0]}

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rd_req = 1'b0;
  logic [2:0]   rd_type = 3'd0;
  logic [31:0]  rd_addr = 32'd0;
  logic         rd_rdy;
  logic         ret_valid;
  logic         ret_last;
  logic [31:0]  ret_data;
  logic         wr_req = 1'b0;
  logic [2:0]   wr_type = 3'd0;
  logic [31:0]  wr_addr = 32'd0;
  logic [3:0]   wr_wstrb = 4'd0;
  logic [127:0] wr_data = 128'd0;
  logic         wr_rdy;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [EW-1:0] exp_q[$];
  logic [31:0]   model_mem [0:(1 << ADDR_W) - 1];
  logic [31:0]   prev_data = 32'd0;
  logic          prev_rstn = 1'b0;

  cache_mem_responder #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic int widx(input logic [31:0] a);
    return int'(a[ADDR_W+1:2]);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_write(input logic line, input logic [31:0] addr,
                             input logic [3:0] strb, input logic [127:0] data);
    int i0;
    i0 = widx(addr);
    if (line) begin
      for (int k = 0; k < 4; k++) model_mem[(i0 & ~3) + k] = data[32*k +: 32];
    end else begin
      for (int b = 0; b < 4; b++)
        if (strb[b]) model_mem[i0][8*b +: 8] = data[8*b +: 8];
    end
  endtask

  // Called at the negedge where rd_rdy=1, so acceptance is the coming posedge.
  task automatic push_read(input logic line, input logic [31:0] addr);
    int a, i0, nb;
    logic [15:0] ec;
    a  = cyc + 1;
    i0 = widx(addr);
    nb = line ? 4 : 1;
    for (int k = 0; k < nb; k++) begin
      ec = 16'(a + RD_LAT - 1 + k * STEP);
      if (line) exp_q.push_back({ec, (k == 3), model_mem[(i0 & ~3) + k]});
      else      exp_q.push_back({ec, 1'b1, model_mem[i0]});
    end
  endtask

  // driver tasks
  task automatic do_write(input logic line, input logic [31:0] addr,
                          input logic [3:0] strb, input logic [127:0] data);
    int n;
    n = 0;
    while (!wr_rdy && n < 200) begin @(negedge clk); n++; end
    if (!wr_rdy) begin
      checks++; failures++;
      $display("FAIL wr_rdy_timeout actual=0 expected=1");
      return;
    end
    wr_type = line ? 3'b100 : 3'b000;
    wr_addr = addr; wr_wstrb = strb; wr_data = data; wr_req = 1'b1;
    model_write(line, addr, strb, data);
    @(negedge clk);
    wr_req = 1'b0;
    chk("wr_rdy_drop", 32'(wr_rdy), 32'd0);
  endtask

  task automatic do_read(input logic line, input logic [31:0] addr);
    int n;
    rd_type = line ? 3'b100 : 3'b000;
    rd_addr = addr;
    rd_req = 1'b1;
    n = 0;
    while (!rd_rdy && n < 200) begin @(negedge clk); n++; end
    if (!rd_rdy) begin
      checks++; failures++;
      $display("FAIL rd_rdy_timeout actual=0 expected=1");
      rd_req = 1'b0;
      return;
    end
    push_read(line, addr);
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    chk("drain_pending_beats", 32'(exp_q.size()), 32'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (ret_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_beat actual data=%h last=%b cyc=%0d expected no beat",
                 ret_data, ret_last, cyc);
      end else begin
        e = exp_q.pop_front();
        if ({16'(cyc), ret_last, ret_data} !== e) begin
          failures++;
          $display("FAIL beat actual cyc=%0d last=%b data=%h expected cyc=%0d last=%b data=%h",
                   cyc, ret_last, ret_data, e[48:33], e[32], e[31:0]);
        end
      end
    end else if (exp_q.size() != 0 && exp_q[0][48:33] == 16'(cyc)) begin
      checks++; failures++;
      $display("FAIL missing_beat actual ret_valid=%b expected beat data=%h at cyc=%0d",
               ret_valid, exp_q[0][31:0], cyc);
      void'(exp_q.pop_front());
    end
    if (resetn && prev_rstn && ret_valid === 1'b0) begin
      checks++;
      if (ret_data !== prev_data) begin
        failures++;
        $display("FAIL ret_data_hold actual=%h expected=%h", ret_data, prev_data);
      end
    end
    prev_data = ret_data;
    prev_rstn = resetn;
  end

  initial begin
    int n;
    int op, idx;
    logic [31:0] addr;

    // reset values, then ready on the first post-reset cycle
    repeat (3) @(negedge clk);
    chk("reset_rd_rdy", 32'(rd_rdy), 32'd0);
    chk("reset_wr_rdy", 32'(wr_rdy), 32'd0);
    chk("reset_ret_valid", 32'(ret_valid), 32'd0);
    chk("reset_ret_data", ret_data, 32'd0);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("idle_rd_rdy", 32'(rd_rdy), 32'd1);
    chk("idle_wr_rdy", 32'(wr_rdy), 32'd1);
    chk("idle_ret_valid", 32'(ret_valid), 32'd0);

    // line write then line read from an unaligned address inside the line
    do_write(1'b1, 32'h1C00_0040, 4'h0, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111});
    do_read(1'b1, 32'h1C00_004C);
    drain();

    // byte-strobed word write over a prior full word
    do_write(1'b0, 32'h0000_0100, 4'hF, {96'd0, 32'h1122_3344});
    do_write(1'b0, 32'h0000_0100, 4'b0101, {96'd0, 32'hAABB_CCDD});
    chk("model_merge", model_mem[64], 32'h11BB_33DD);
    do_read(1'b0, 32'h0000_0100);
    drain();

    // same-cycle write and read: write first, read held until accepted
    n = 0;
    while (!wr_rdy && n < 200) begin @(negedge clk); n++; end
    wr_type = 3'b000; wr_addr = 32'h200; wr_wstrb = 4'hF; wr_data = 128'h5; wr_req = 1'b1;
    rd_type = 3'b000; rd_addr = 32'h200; rd_req = 1'b1;
    model_write(1'b0, 32'h200, 4'hF, 128'h5);
    @(negedge clk);
    wr_req = 1'b0;
    n = 0;
    while (!rd_rdy && n < 50) begin n++; @(negedge clk); end
    chk("rd_rdy_low_cycles", 32'(n), 32'(WR_LAT));
    push_read(1'b0, 32'h200);
    @(negedge clk);
    rd_req = 1'b0;
    drain();

    // address wrap
    do_write(1'b0, 32'h0001_0000, 4'hF, {96'd0, 32'hCAFE_F00D});
    do_read(1'b0, 32'h0000_0000);
    drain();

    // preload a small region with random upper address bits, then random traffic
    for (int i = 0; i < 16; i++)
      do_write(1'b1, ($urandom & 32'hFFFF_0000) | 32'(i * 16),
               4'h0, {$urandom, $urandom, $urandom, $urandom});
    for (int it = 0; it < 300; it++) begin
      op   = $urandom_range(0, 3);
      idx  = $urandom_range(0, 63);
      addr = ($urandom & 32'hFFFF_0003) | (32'(idx) << 2);
      case (op)
        0: do_write(1'b1, addr, 4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});
        1: do_write(1'b0, addr, 4'($urandom_range(0, 15)), {$urandom, $urandom, $urandom, $urandom});
        2: do_read(1'b1, addr);
        default: do_read(1'b0, addr);
      endcase
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain();

    // reset during the second beat of a line read aborts the burst
    do_read(1'b1, 32'h0000_0080);
    n = 0;
    while (exp_q.size() != 2 && n < 50) begin @(negedge clk); #1; n++; end
    chk("abort_reached_beat2", 32'(exp_q.size()), 32'd2);
    resetn = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("abort_ret_valid", 32'(ret_valid), 32'd0);
    chk("abort_rd_rdy", 32'(rd_rdy), 32'd0);
    chk("abort_ret_data", ret_data, 32'd0);
    @(negedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("post_abort_rd_rdy", 32'(rd_rdy), 32'd1);
    chk("post_abort_wr_rdy", 32'(wr_rdy), 32'd1);
    repeat (8) @(negedge clk);
    do_read(1'b0, 32'h0000_0084);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
